// File: rtl/psm_ascii_pkg.sv
// Shared constants for the ASCII state-name encoder: sm_psm codes, name table,
// control bytes and the encoder FSM encoding.
package psm_ascii_pkg;

  localparam int unsigned NAME_CHARS = 6;
  localparam int unsigned NAME_W     = 8 * NAME_CHARS;

  localparam logic [2:0] PSM_IDL = 3'd0;
  localparam logic [2:0] PSM_RST = 3'd6;
  localparam logic [2:0] PSM_ZOT = 3'd7;

  // First character of a name lands in the most significant byte.
  localparam logic [NAME_W-1:0] NAME_IDL = "psmidl";
  localparam logic [NAME_W-1:0] NAME_RST = "psmrst";
  localparam logic [NAME_W-1:0] NAME_ZOT = "psmzot";

  localparam logic [7:0] CH_TERM = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_US   = 8'h5F;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/psm_name_match.sv
// Combinational name-table lookup; add new state names here.
module psm_name_match
  import psm_ascii_pkg::*;
(
  input  logic [NAME_W-1:0] buffer,
  input  logic [2:0]        count,
  output logic              hit,
  output logic [2:0]        code
);

  always_comb begin
    hit  = 1'b0;
    code = '0;
    if (count == 3'(NAME_CHARS)) begin
      case (buffer)
        NAME_IDL: begin hit = 1'b1; code = PSM_IDL; end
        NAME_RST: begin hit = 1'b1; code = PSM_RST; end
        NAME_ZOT: begin hit = 1'b1; code = PSM_ZOT; end
        default:  begin hit = 1'b0; code = '0;      end
      endcase
    end
  end

endmodule

// File: rtl/psm_ascii_encode.sv
// ASCII state-name to sm_psm code encoder: folds/filters console bytes, collects
// one line, looks it up and holds the result until the consumer takes it.
module psm_ascii_encode
  import psm_ascii_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 6,
  parameter logic [7:0]  TERM      = 8'h0A
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_CHARS);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NAME_W-1:0] buf_q, buf_d;
  logic              rdy_q, rdy_d;
  logic              cmp_q, cmp_d;
  logic              vld_q, vld_d;
  logic [2:0]        code_q, code_d;
  logic              err_q, err_d;

  logic [7:0] byte_f;
  logic       accept, is_term, is_drop;
  logic       hit;
  logic [2:0] m_code;

  psm_name_match u_match (
    .buffer (buf_q),
    .count  (cnt_q),
    .hit    (hit),
    .code   (m_code)
  );

  assign byte_f  = fold_case(in_data);
  assign accept  = in_valid & rdy_q;
  assign is_term = (byte_f == TERM);
  assign is_drop = (byte_f == CH_US) || (byte_f == CH_CR);

  // cmp_q marks the cycle after TERM was taken: the lookup result is registered
  // then, with in_ready already low so no byte can slip in before HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    rdy_d   = rdy_q;
    cmp_d   = 1'b0;
    vld_d   = vld_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      ST_COLLECT: begin
        if (cmp_q) begin
          vld_d   = 1'b1;
          code_d  = hit ? m_code : PSM_IDL;
          err_d   = ~hit;
          state_d = ST_HOLD;
        end else begin
          rdy_d = 1'b1;
          if (accept) begin
            if (is_term) begin
              if (cnt_q != '0) begin
                cmp_d = 1'b1;
                rdy_d = 1'b0;
              end
            end else if (!is_drop) begin
              if (cnt_q == MAX_CNT) begin
                state_d = ST_DISCARD;
              end else begin
                buf_d = {buf_q[NAME_W-9:0], byte_f};
                cnt_d = cnt_q + 3'd1;
              end
            end
          end
        end
      end
      ST_DISCARD: begin
        if (cmp_q) begin
          vld_d   = 1'b1;
          code_d  = '0;
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          rdy_d = 1'b1;
          if (accept && is_term) begin
            cmp_d = 1'b1;
            rdy_d = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        rdy_d = 1'b0;
        if (vld_q && out_ready) begin
          vld_d   = 1'b0;
          cnt_d   = '0;
          buf_d   = '0;
          rdy_d   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      buf_q   <= '0;
      rdy_q   <= 1'b0;
      cmp_q   <= 1'b0;
      vld_q   <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      rdy_q   <= rdy_d;
      cmp_q   <= cmp_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_code  = code_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_psm_ascii_encode.sv
// Directed and randomised-handshake checks of the ASCII state-name encoder.
module tb_psm_ascii_encode;

  typedef struct {
    logic [2:0] code;
    logic       err;
    int         rise;
  } res_t;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         edge_cnt = 0;
  int         last_acc_edge = 0;
  int         rise_edge = 0;
  logic       prev_v = 1'b0;
  int         rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
  logic       rnd_rdy = 1'b0;
  res_t       resq[$];

  psm_ascii_encode #(.MAX_CHARS(6), .TERM(8'h0A)) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  assign out_ready = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) rnd_rdy = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    #1;
    if (!reset_l) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) rise_edge = edge_cnt;
      prev_v = out_valid;
      if (out_valid && out_ready) resq.push_back('{out_code, out_err, rise_edge});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    last_acc_edge = edge_cnt;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
      send_byte(s[i]);
    end
  endtask

  task automatic expect_result(input string tag, input logic [2:0] code, input logic err,
                               output res_t r);
    int unsigned w = 0;
    while (resq.size() == 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (resq.size() == 0) begin
      check({tag, "_timeout"}, 32'(resq.size()), 32'd1);
      r = '{3'd0, 1'b0, 0};
      return;
    end
    r = resq.pop_front();
    check({tag, "_code"}, 32'(r.code), 32'(code));
    check({tag, "_err"},  32'(r.err),  32'(err));
  endtask

  function automatic void model(input string s, output bit has, output logic [2:0] code,
                                output logic err);
    string n = "";
    int    cnt = 0;
    bit    ovf = 0;
    byte   c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0A) break;
      if (c >= "A" && c <= "Z") c = c + 8'sd32;
      if (c == "_" || c == 8'h0D) continue;
      if (cnt == 6) ovf = 1;
      else begin
        n = $sformatf("%s%c", n, c);
        cnt++;
      end
    end
    has  = (cnt > 0);
    code = 3'd0;
    err  = 1'b1;
    if (!ovf) begin
      if (n == "psmidl")      begin code = 3'd0; err = 1'b0; end
      else if (n == "psmrst") begin code = 3'd6; err = 1'b0; end
      else if (n == "psmzot") begin code = 3'd7; err = 1'b0; end
    end
  endfunction

  initial begin
    res_t  r;
    bit    stable;
    bit    has;
    logic [2:0] mc;
    logic  me;
    logic [2:0] hc;
    logic  he;
    string lines[10];

    reset_l  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    reset_l = 1'b1;
    @(negedge clk);
    check("first_edge_in_ready", 32'(in_ready), 32'd1);

    // 1: basic decode and latency
    send_line("psmrst\n", 0);
    expect_result("t1", 3'd6, 1'b0, r);
    check("t1_latency", 32'(r.rise - last_acc_edge), 32'd1);
    @(negedge clk);
    check("t1_single_pulse", 32'(out_valid), 32'd0);

    // 2: folding and filtering
    send_line("PSM_ZOT\r\n", 0);
    expect_result("t2_zot", 3'd7, 1'b0, r);
    send_line("psm_idl\n", 0);
    expect_result("t2_idl", 3'd0, 1'b0, r);

    // 3: unknown, short, empty
    send_line("psmfoo\n", 0);
    expect_result("t3_foo", 3'd0, 1'b1, r);
    send_line("psmid\n", 0);
    expect_result("t3_short", 3'd0, 1'b1, r);
    send_line("\n", 0);
    repeat (6) @(negedge clk);
    check("t3_empty_no_result", 32'(resq.size()), 32'd0);
    check("t3_empty_no_valid", 32'(out_valid), 32'd0);

    // 4: overflow then clean recovery
    send_line("psmrstxyz\n", 0);
    expect_result("t4_ovf", 3'd0, 1'b1, r);
    send_line("psmidl\n", 0);
    expect_result("t4_after", 3'd0, 1'b0, r);

    // 5: back-pressure on the result
    rdy_mode = 0;
    send_line("psmrst\n", 0);
    for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
    check("t5_valid", 32'(out_valid), 32'd1);
    hc = out_code;
    he = out_err;
    in_valid = 1'b1;
    in_data  = "p";
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_code !== hc || out_err !== he || in_ready) stable = 1'b0;
    end
    check("t5_hold_stable", 32'(stable), 32'd1);
    rdy_mode = 1;
    @(negedge clk);
    check("t5_ready_after_hs", 32'(in_ready), 32'd1);
    check("t5_valid_dropped", 32'(out_valid), 32'd0);
    expect_result("t5_held", 3'd6, 1'b0, r);
    @(negedge clk);
    in_valid = 1'b0;
    send_line("smzot\n", 0);
    expect_result("t5_no_loss", 3'd7, 1'b0, r);

    // 6: reset mid-line and mid-hold
    send_line("psm", 0);
    reset_l = 1'b0;
    #1;
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    send_line("rst\n", 0);
    expect_result("t6_no_stale", 3'd0, 1'b1, r);

    rdy_mode = 0;
    send_line("psmzot\n", 0);
    for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("t6_hold_rst_valid", 32'(out_valid), 32'd0);
    check("t6_hold_rst_code", 32'(out_code), 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    check("t6_no_pending", 32'(resq.size()), 32'd0);

    // random handshake stress against the line model
    lines = '{"psmidl\n", "PSMRST\n", "psm_zot\r\n", "psmzo\n", "\n",
              "psmrstx\n", "Psm_Idl\n", "xyz\n", "psmzotzot\n", "_\r\n"};
    rdy_mode = 2;
    for (int it = 0; it < 30; it++) begin
      int k;
      k = int'($urandom_range(0, 9));
      model(lines[k], has, mc, me);
      send_line(lines[k], 1);
      if (has) expect_result($sformatf("stress%0d", it), mc, me, r);
    end
    rdy_mode = 1;
    repeat (6) @(negedge clk);
    check("stress_no_extra", 32'(resq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
